// File: rtl/rf_access_arbiter_if.sv
// Requester handshake, bulk-clear control and register-file pins of rf_access_arbiter.
// The slave modport is the arbiter's view; master is the requesters/register-file side.
interface rf_access_arbiter_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NREQ   = 2
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*WIDTH-1:0]  req_wdata;
    logic [NREQ-1:0]        resp_valid;
    logic [WIDTH-1:0]       resp_rdata;

    logic                   clr_start;
    logic                   clr_busy;
    logic                   clr_done;

    logic                   rf_en;
    logic                   rf_r_or_w;
    logic [ADDR_W-1:0]      rf_addr;
    logic [WIDTH-1:0]       rf_wdata;
    logic [WIDTH-1:0]       rf_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, clr_start, rf_rdata,
        output req_ready, resp_valid, resp_rdata, clr_busy, clr_done,
               rf_en, rf_r_or_w, rf_addr, rf_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, clr_start, rf_rdata,
        input  req_ready, resp_valid, resp_rdata, clr_busy, clr_done,
               rf_en, rf_r_or_w, rf_addr, rf_wdata
    );
endinterface

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter giving NREQ requesters one-at-a-time access to a single-port
// register file, with a bulk-clear sequencer that zeroes every register.
module rf_access_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned REG_NUM = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned NREQ    = 2
) (
    input logic                clk,
    input logic                rst,
    rf_access_arbiter_if.slave bus
);

    localparam int unsigned PtrW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StResp, StClear} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   rr_q, rr_d;
    logic [PtrW-1:0]   gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_done_q, clr_done_d;

    logic [PtrW-1:0]   win;
    logic              win_found;
    int                idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_wdata;

    // First valid requester at or after rr_q, wrapping around.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = int'(rr_q) + k;
            if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
            if (!win_found && bus.req_valid[PtrW'(idx)]) begin
                win_found = 1'b1;
                win       = PtrW'(idx);
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (win == PtrW'(i)) begin
                sel_we    = bus.req_we[i];
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;

        bus.req_ready  = '0;
        bus.resp_valid = '0;
        bus.clr_busy   = 1'b0;
        bus.rf_en      = 1'b0;
        bus.rf_r_or_w  = 1'b0;
        bus.rf_addr    = '0;
        bus.rf_wdata   = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.clr_start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end else if (win_found && !rst) begin
                    // Grant is withheld while in reset so no handshake is silently dropped.
                    bus.req_ready = NREQ'(1) << win;
                    gnt_d         = win;
                    we_d          = sel_we;
                    addr_d        = sel_addr;
                    wdata_d       = sel_wdata;
                    state_d       = StAccess;
                end
            end
            StAccess: begin
                bus.rf_en     = 1'b1;
                bus.rf_r_or_w = we_q;
                bus.rf_addr   = addr_q;
                bus.rf_wdata  = we_q ? wdata_q : '0;
                if (!we_q) rdata_d = bus.rf_rdata;
                state_d = StResp;
            end
            StResp: begin
                bus.resp_valid = NREQ'(1) << gnt_q;
                rr_d           = (int'(gnt_q) == int'(NREQ) - 1) ? '0 : gnt_q + 1'b1;
                state_d        = StIdle;
            end
            StClear: begin
                bus.clr_busy  = 1'b1;
                bus.rf_en     = 1'b1;
                bus.rf_r_or_w = 1'b1;
                bus.rf_addr   = cnt_q;
                if (cnt_q == ADDR_W'(REG_NUM - 1)) begin
                    cnt_d      = '0;
                    clr_done_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.clr_done   = clr_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_q       <= '0;
            gnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
        end
    end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: a cycle-keyed transaction model predicts every output each
// cycle, while directed sequences add hand-computed literal checks.
module tb_rf_access_arbiter;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned REG_NUM = 16;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned NREQ    = 2;
    localparam int          RING    = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_access_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREQ(NREQ)) bus ();

    rf_access_arbiter #(
        .WIDTH  (WIDTH),
        .REG_NUM(REG_NUM),
        .ADDR_W (ADDR_W),
        .NREQ   (NREQ)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Register file attached to the arbiter
    logic [WIDTH-1:0] rf_mem [REG_NUM];
    always @(posedge clk) if (bus.rf_en && bus.rf_r_or_w) rf_mem[bus.rf_addr] <= bus.rf_wdata;
    assign bus.rf_rdata = (bus.rf_en && !bus.rf_r_or_w) ? rf_mem[bus.rf_addr] : '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    // Model: expected per-cycle outputs scheduled into a ring keyed by cycle number.
    bit                e_en    [RING];
    bit                e_we    [RING];
    bit [ADDR_W-1:0]   e_addr  [RING];
    bit [WIDTH-1:0]    e_wd    [RING];
    bit                e_busy  [RING];
    bit                e_done  [RING];
    bit [NREQ-1:0]     e_resp  [RING];
    bit                e_setrd [RING];
    bit [WIDTH-1:0]    e_rd    [RING];
    bit [WIDTH-1:0]    mem_m   [REG_NUM];
    bit [WIDTH-1:0]    m_rdata = '0;
    int                m_rr    = 0;
    int                free_at = 0;
    bit                armed   = 1'b0;

    always @(negedge clk) begin
        int i, j, g, a;
        bit found, we;
        bit [NREQ-1:0] x_ready;
        bit x_en, x_we, x_busy, x_done;
        bit [ADDR_W-1:0] x_addr;
        bit [WIDTH-1:0] x_wd, d;
        bit [NREQ-1:0] x_resp;
        i = cyc % RING;
        x_en = e_en[i]; x_we = e_we[i]; x_addr = e_addr[i]; x_wd = e_wd[i];
        x_busy = e_busy[i]; x_done = e_done[i]; x_resp = e_resp[i];
        if (e_setrd[i]) m_rdata = e_rd[i];
        e_en[i] = 0; e_we[i] = 0; e_addr[i] = 0; e_wd[i] = 0; e_busy[i] = 0;
        e_done[i] = 0; e_resp[i] = 0; e_setrd[i] = 0;
        x_ready = '0;
        if (armed && !rst && cyc >= free_at) begin
            if (bus.clr_start === 1'b1) begin
                for (int r = 0; r < int'(REG_NUM); r++) begin
                    j = (cyc + 1 + r) % RING;
                    e_en[j] = 1; e_we[j] = 1; e_addr[j] = ADDR_W'(r); e_busy[j] = 1;
                    mem_m[r] = '0;
                end
                e_done[(cyc + int'(REG_NUM) + 1) % RING] = 1;
                free_at = cyc + int'(REG_NUM) + 1;
            end else begin
                found = 0; g = 0;
                for (int k = 0; k < int'(NREQ); k++) begin
                    if (!found && bus.req_valid[(m_rr + k) % int'(NREQ)] === 1'b1) begin
                        found = 1; g = (m_rr + k) % int'(NREQ);
                    end
                end
                if (found) begin
                    x_ready[g] = 1;
                    we = bus.req_we[g];
                    a  = int'(bus.req_addr[g*ADDR_W +: ADDR_W]);
                    d  = bus.req_wdata[g*WIDTH +: WIDTH];
                    j  = (cyc + 1) % RING;
                    e_en[j] = 1; e_we[j] = we; e_addr[j] = ADDR_W'(a);
                    e_wd[j] = we ? d : '0;
                    j = (cyc + 2) % RING;
                    e_resp[j][g] = 1;
                    if (we) mem_m[a] = d;
                    else begin e_setrd[j] = 1; e_rd[j] = mem_m[a]; end
                    m_rr = (g + 1) % int'(NREQ);
                    free_at = cyc + 3;
                end
            end
        end
        if (armed) begin
            chk("req_ready",  32'(bus.req_ready),  32'(x_ready));
            chk("resp_valid", 32'(bus.resp_valid), 32'(x_resp));
            chk("resp_rdata", 32'(bus.resp_rdata), 32'(m_rdata));
            chk("clr_busy",   32'(bus.clr_busy),   32'(x_busy));
            chk("clr_done",   32'(bus.clr_done),   32'(x_done));
            chk("rf_en",      32'(bus.rf_en),      32'(x_en));
            chk("rf_r_or_w",  32'(bus.rf_r_or_w),  32'(x_we));
            chk("rf_addr",    32'(bus.rf_addr),    32'(x_addr));
            chk("rf_wdata",   32'(bus.rf_wdata),   32'(x_wd));
        end
        if (rst) begin
            for (int r = 0; r < RING; r++) begin
                e_en[r] = 0; e_we[r] = 0; e_addr[r] = 0; e_wd[r] = 0; e_busy[r] = 0;
                e_done[r] = 0; e_resp[r] = 0; e_setrd[r] = 0;
            end
            m_rr = 0; m_rdata = '0; free_at = cyc + 1; armed = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input bit v, input bit we, input int addr, input int data);
        bus.req_valid[r] = v;
        bus.req_we[r]    = we;
        bus.req_addr[r*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        bus.req_wdata[r*WIDTH +: WIDTH]  = WIDTH'(data);
    endtask

    // Leaves time 2 units after the edge that starts the response cycle.
    task automatic do_access(input int r, input bit we, input int addr, input int data,
                             output int rd);
        int n;
        rd = 0;
        set_req(r, 1'b1, we, addr, data);
        #1;
        n = 0;
        while (bus.req_ready[r] !== 1'b1 && n < 60) begin tick(); #1; n++; end
        if (n >= 60) begin
            chk("grant_timeout", 1, 0);
            set_req(r, 1'b0, 1'b0, 0, 0);
            return;
        end
        tick();
        set_req(r, 1'b0, 1'b0, 0, 0);
        #1;
        n = 0;
        while (bus.resp_valid[r] !== 1'b1 && n < 10) begin tick(); #1; n++; end
        if (n >= 10) chk("resp_timeout", 1, 0);
        rd = int'(bus.resp_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int rd, ng, nr, busy_n;
        int gq[$];
        int rq_who[$], rq_dat[$], rq_cyc[$];
        rst = 1'b1;
        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.clr_start = 1'b0;
        repeat (3) tick();
        #1;
        chk("rst_rf_en", 32'(bus.rf_en), 0);
        chk("rst_resp_rdata", 32'(bus.resp_rdata), 0);
        rst = 1'b0;

        // Single write then read from requester 0
        tick();
        set_req(0, 1'b1, 1'b1, 3, 16'hBEEF);
        #1 chk("t1_ready", 32'(bus.req_ready), 1);
        tick();
        set_req(0, 1'b0, 1'b0, 0, 0);
        #1;
        chk("t1_acc_en", 32'(bus.rf_en), 1);
        chk("t1_acc_w", 32'(bus.rf_r_or_w), 1);
        chk("t1_acc_addr", 32'(bus.rf_addr), 3);
        chk("t1_acc_wd", 32'(bus.rf_wdata), 32'h0000BEEF);
        tick();
        #1 chk("t1_wresp", 32'(bus.resp_valid), 1);
        tick();
        set_req(0, 1'b1, 1'b0, 3, 0);
        #1 chk("t1_rready", 32'(bus.req_ready), 1);
        tick();
        set_req(0, 1'b0, 1'b0, 0, 0);
        #1;
        chk("t1_racc_dir", 32'(bus.rf_r_or_w), 0);
        chk("t1_racc_addr", 32'(bus.rf_addr), 3);
        tick();
        #1;
        chk("t1_rresp", 32'(bus.resp_valid), 1);
        chk("t1_rdata", 32'(bus.resp_rdata), 32'h0000BEEF);

        // Idle hygiene
        for (int k = 0; k < 10; k++) begin
            tick();
            #1;
            chk("idle_en", 32'(bus.rf_en), 0);
            chk("idle_addr", 32'(bus.rf_addr), 0);
            chk("idle_ready", 32'(bus.req_ready), 0);
            chk("idle_resp", 32'(bus.resp_valid), 0);
        end

        // Preload, then bulk clear
        for (int k = 0; k < int'(REG_NUM); k++) do_access(0, 1'b1, k, 16'h1111, rd);
        do_access(1, 1'b0, 9, 0, rd);
        chk("preload_rd9", 32'(rd), 32'h1111);
        tick();
        bus.clr_start = 1'b1;
        #1 chk("clr_no_ready", 32'(bus.req_ready), 0);
        tick();
        bus.clr_start = 1'b0;
        #1;
        busy_n = 0;
        while (bus.clr_busy === 1'b1 && busy_n < 40) begin
            chk("clr_seq_addr", 32'(bus.rf_addr), 32'(busy_n));
            chk("clr_seq_wd", 32'(bus.rf_wdata), 0);
            busy_n++;
            tick();
            #1;
        end
        chk("clr_len", 32'(busy_n), 16);
        chk("clr_done_pulse", 32'(bus.clr_done), 1);
        tick();
        #1 chk("clr_done_once", 32'(bus.clr_done), 0);
        do_access(0, 1'b0, 0, 0, rd);
        chk("clr_rd0", 32'(rd), 0);
        do_access(1, 1'b0, 15, 0, rd);
        chk("clr_rd15", 32'(rd), 0);
        do_access(0, 1'b1, 1, 16'h0101, rd);
        do_access(1, 1'b1, 2, 16'h0202, rd);

        // Contention from reset
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 1, 0);
        set_req(1, 1'b1, 1'b0, 2, 0);
        ng = 0;
        nr = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.req_ready != 0 && ng < 4) begin
                gq.push_back(bus.req_ready[1] ? 1 : 0);
                ng++;
            end
            if (bus.resp_valid != 0) begin
                rq_who.push_back(bus.resp_valid[1] ? 1 : 0);
                rq_dat.push_back(int'(bus.resp_rdata));
                rq_cyc.push_back(k);
                nr++;
            end
            tick();
            if (ng == 4) begin
                set_req(0, 1'b0, 1'b0, 0, 0);
                set_req(1, 1'b0, 1'b0, 0, 0);
            end
        end
        chk("cont_ngrants", 32'(ng), 4);
        chk("cont_nresp", 32'(nr), 4);
        if (ng == 4 && nr == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("cont_grant_order", 32'(gq[k]), 32'(k % 2));
                chk("cont_resp_who", 32'(rq_who[k]), 32'(k % 2));
                chk("cont_resp_data", 32'(rq_dat[k]), (k % 2) ? 32'h0202 : 32'h0101);
                if (k > 0) chk("cont_resp_gap", 32'(rq_cyc[k] - rq_cyc[k-1]), 3);
            end
        end

        // clr_start wins over a simultaneous request
        tick();
        bus.clr_start = 1'b1;
        set_req(1, 1'b1, 1'b0, 5, 0);
        #1 chk("clrwin_ready1", 32'(bus.req_ready[1]), 0);
        tick();
        bus.clr_start = 1'b0;
        #1;
        busy_n = 0;
        while (bus.clr_done !== 1'b1 && busy_n < 40) begin tick(); #1; busy_n++; end
        chk("clrwin_done_seen", 32'(busy_n < 40), 1);
        chk("clrwin_grant1", 32'(bus.req_ready), 2);
        tick();
        set_req(1, 1'b0, 1'b0, 0, 0);
        tick();
        #1;
        chk("clrwin_resp1", 32'(bus.resp_valid), 2);
        chk("clrwin_rdata", 32'(bus.resp_rdata), 0);

        // Reset during a read ACCESS of requester 1, with rr pointing at 1
        do_access(0, 1'b1, 4, 16'h5A5A, rd);
        tick();
        set_req(1, 1'b1, 1'b0, 4, 0);
        #1 chk("rstmid_grant1", 32'(bus.req_ready), 2);
        tick();
        set_req(1, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        #1 chk("rstmid_in_access", 32'(bus.rf_en), 1);
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_resp", 32'(bus.resp_valid), 0);
        chk("rstmid_en", 32'(bus.rf_en), 0);
        chk("rstmid_addr", 32'(bus.rf_addr), 0);
        chk("rstmid_busy", 32'(bus.clr_busy), 0);
        chk("rstmid_rdata", 32'(bus.resp_rdata), 0);
        tick();
        set_req(0, 1'b1, 1'b0, 4, 0);
        set_req(1, 1'b1, 1'b0, 4, 0);
        #1 chk("rstmid_rr0", 32'(bus.req_ready), 1);
        tick();
        set_req(0, 1'b0, 1'b0, 0, 0);
        set_req(1, 1'b0, 1'b0, 0, 0);
        #1 chk("rstmid_no_resp1", 32'(bus.resp_valid[1]), 0);
        tick();
        #1;
        chk("rstmid_resp0", 32'(bus.resp_valid), 1);
        chk("rstmid_rd4", 32'(bus.resp_rdata), 32'h5A5A);

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
